// File: rtl/kf8088_bus_cycle_gen_pkg.sv
// Shared definitions for the KFPC-XT bus-cycle initiator: status codes,
// bus-state encoding and read/write classification helpers.
package kf8088_pkg;

    localparam int unsigned STATUS_W = 3;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned DATA_W   = 8;

    localparam logic [STATUS_W-1:0] STATUS_INTA      = 3'b000;
    localparam logic [STATUS_W-1:0] STATUS_IO_READ   = 3'b001;
    localparam logic [STATUS_W-1:0] STATUS_IO_WRITE  = 3'b010;
    localparam logic [STATUS_W-1:0] STATUS_HALT      = 3'b011;
    localparam logic [STATUS_W-1:0] STATUS_CODE      = 3'b100;
    localparam logic [STATUS_W-1:0] STATUS_MEM_READ  = 3'b101;
    localparam logic [STATUS_W-1:0] STATUS_MEM_WRITE = 3'b110;
    localparam logic [STATUS_W-1:0] STATUS_PASSIVE   = 3'b111;

    typedef enum logic [2:0] {
        BUS_IDLE = 3'd0,
        BUS_T1   = 3'd1,
        BUS_T2   = 3'd2,
        BUS_T3   = 3'd3,
        BUS_TW   = 3'd4,
        BUS_T4   = 3'd5
    } bus_state_t;

    function automatic logic is_write(input logic [STATUS_W-1:0] cycle_type);
        return (cycle_type == STATUS_IO_WRITE) || (cycle_type == STATUS_MEM_WRITE);
    endfunction

    function automatic logic is_read(input logic [STATUS_W-1:0] cycle_type);
        return (cycle_type == STATUS_INTA) || (cycle_type == STATUS_IO_READ) ||
               (cycle_type == STATUS_CODE) || (cycle_type == STATUS_MEM_READ);
    endfunction

endpackage

// File: rtl/kf8088_bus_cycle_gen_if.sv
// Request/acknowledge and 8088 bus-side signals of the bus-cycle initiator.
interface kf8088_bus_cycle_gen_if;
    import kf8088_pkg::*;

    logic                request;
    logic                request_ready;
    logic [STATUS_W-1:0] request_type;
    logic [ADDR_W-1:0]   request_address;
    logic [DATA_W-1:0]   request_write_data;
    logic [STATUS_W-1:0] processor_status;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data_out;
    logic                data_out_enable;
    logic [DATA_W-1:0]   data_in;
    logic                ready;
    logic                acknowledge;
    logic [DATA_W-1:0]   read_data;

    modport master (
        input  request, request_type, request_address, request_write_data,
        input  data_in, ready,
        output request_ready, processor_status, address, data_out,
        output data_out_enable, acknowledge, read_data
    );

    modport slave (
        output request, request_type, request_address, request_write_data,
        output data_in, ready,
        input  request_ready, processor_status, address, data_out,
        input  data_out_enable, acknowledge, read_data
    );

endinterface

// File: rtl/kf8088_bus_cycle_gen.sv
// 8088-style bus-cycle initiator: sequences T1..T4 with wait states and
// drives the active-low status lines decoded by the 8288.
module kf8088_bus_cycle_gen
    import kf8088_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    kf8088_bus_cycle_gen_if.master bus
);

    localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

    bus_state_t          r_state;
    bus_state_t          w_state_next;
    logic [CNT_W-1:0]    r_wait;
    logic [STATUS_W-1:0] r_type;
    logic [STATUS_W-1:0] r_status;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_out_enable;
    logic                r_acknowledge;
    logic [DATA_W-1:0]   r_read_data;

    logic                w_request_ready;
    logic                w_accept;
    logic                w_enter_t4;
    logic                w_wait_dec;
    logic [STATUS_W-1:0] w_type_next;
    logic [STATUS_W-1:0] w_status_next;
    logic                w_data_out_enable_next;

    assign w_request_ready = (r_state == BUS_IDLE) || (r_state == BUS_T4);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_next           = r_state;
        w_enter_t4             = 1'b0;
        w_wait_dec             = 1'b0;
        w_accept               = bus.request && w_request_ready &&
                                 (bus.request_type != STATUS_PASSIVE);
        w_type_next            = w_accept ? bus.request_type : r_type;
        w_status_next          = STATUS_PASSIVE;
        w_data_out_enable_next = 1'b0;

        case (r_state)
            BUS_IDLE: begin
                if (w_accept) begin
                    w_state_next = BUS_T1;
                end
            end
            BUS_T1: w_state_next = BUS_T2;
            BUS_T2: w_state_next = BUS_T3;
            BUS_T3, BUS_TW: begin
                // Halt never waits; other cycles drain the forced count, then honour ready
                if ((r_type == STATUS_HALT) || ((r_wait == '0) && bus.ready)) begin
                    w_state_next = BUS_T4;
                    w_enter_t4   = 1'b1;
                end else begin
                    w_state_next = BUS_TW;
                    w_wait_dec   = (r_wait != '0);
                end
            end
            BUS_T4: begin
                w_state_next = w_accept ? BUS_T1 : BUS_IDLE;
            end
            default: w_state_next = BUS_IDLE;
        endcase

        case (w_state_next)
            BUS_T1, BUS_T2, BUS_T3, BUS_TW: w_status_next = w_type_next;
            default:                        w_status_next = STATUS_PASSIVE;
        endcase

        case (w_state_next)
            BUS_T2, BUS_T3, BUS_TW, BUS_T4: w_data_out_enable_next = is_write(w_type_next);
            default:                        w_data_out_enable_next = 1'b0;
        endcase
    end

    // Cycle context, wait counter and registered bus outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_type            <= STATUS_PASSIVE;
            r_wait            <= '0;
            r_status          <= STATUS_PASSIVE;
            r_address         <= '0;
            r_data_out        <= '0;
            r_data_out_enable <= 1'b0;
            r_acknowledge     <= 1'b0;
            r_read_data       <= '0;
        end else begin
            if (w_accept) begin
                r_type     <= bus.request_type;
                r_address  <= bus.request_address;
                r_data_out <= bus.request_write_data;
                r_wait     <= CNT_W'(WAIT_STATES);
            end else if (w_wait_dec) begin
                r_wait <= r_wait - CNT_W'(1);
            end

            if (w_enter_t4 && is_read(r_type)) begin
                r_read_data <= bus.data_in;
            end

            r_status          <= w_status_next;
            r_data_out_enable <= w_data_out_enable_next;
            r_acknowledge     <= (w_state_next == BUS_T4);
        end
    end

    assign bus.request_ready    = w_request_ready;
    assign bus.processor_status = r_status;
    assign bus.address          = r_address;
    assign bus.data_out         = r_data_out;
    assign bus.data_out_enable  = r_data_out_enable;
    assign bus.acknowledge      = r_acknowledge;
    assign bus.read_data        = r_read_data;

endmodule

// File: tb/tb_kf8088_bus_cycle_gen.sv
// Directed bench for the bus-cycle initiator with WAIT_STATES of 0 and 2.
module tb_kf8088_bus_cycle_gen;
    import kf8088_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    kf8088_bus_cycle_gen_if bus0 ();
    kf8088_bus_cycle_gen_if bus2 ();

    kf8088_bus_cycle_gen #(.WAIT_STATES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    kf8088_bus_cycle_gen #(.WAIT_STATES(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc_no, got, exp);
    endtask

    task automatic start0(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d);
        bus0.request            = 1'b1;
        bus0.request_type       = t;
        bus0.request_address    = a;
        bus0.request_write_data = d;
    endtask

    initial begin
        reset = 1'b1;
        bus0.request = 1'b0; bus0.request_type = 3'b000; bus0.request_address = '0;
        bus0.request_write_data = '0; bus0.data_in = '0; bus0.ready = 1'b1;
        bus2.request = 1'b0; bus2.request_type = 3'b000; bus2.request_address = '0;
        bus2.request_write_data = '0; bus2.data_in = '0; bus2.ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset values
        chk("rst_status", 32'(bus0.processor_status), 32'h7);
        chk("rst_ack",    32'(bus0.acknowledge),      32'h0);
        chk("rst_rdy",    32'(bus0.request_ready),    32'h1);
        chk("rst_addr",   32'(bus0.address),          32'h0);
        chk("rst_dout",   32'(bus0.data_out),         32'h0);
        chk("rst_oe",     32'(bus0.data_out_enable),  32'h0);
        chk("rst_rdata",  32'(bus0.read_data),        32'h0);
        chk("rst_status2", 32'(bus2.processor_status), 32'h7);

        // Illegal type is never accepted
        start0(3'b111, 20'h12345, 8'h00);
        @(negedge clock);
        chk("ill_status", 32'(bus0.processor_status), 32'h7);
        chk("ill_rdy",    32'(bus0.request_ready),    32'h1);
        chk("ill_ack",    32'(bus0.acknowledge),      32'h0);
        bus0.request = 1'b0;

        // Mem read, no waits
        bus0.ready = 1'b1; bus0.data_in = 8'h5A;
        start0(3'b101, 20'hFFFF0, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus0.request = 1'b0;
            chk("mr_status", 32'(bus0.processor_status), (c <= 3) ? 32'h5 : 32'h7);
            chk("mr_ack",    32'(bus0.acknowledge),      (c == 4) ? 32'h1 : 32'h0);
            chk("mr_rdy",    32'(bus0.request_ready),    (c >= 4) ? 32'h1 : 32'h0);
            if (c == 1) chk("mr_addr",  32'(bus0.address),   32'hFFFF0);
            if (c == 4) chk("mr_rdata", 32'(bus0.read_data), 32'h5A);
        end

        // IO write with three ready-driven waits
        bus0.ready = 1'b0;
        start0(3'b010, 20'h00061, 8'h3C);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus0.request = 1'b0;
            chk("iow_status", 32'(bus0.processor_status), (c <= 6) ? 32'h2 : 32'h7);
            chk("iow_oe",  32'(bus0.data_out_enable), (c >= 2 && c <= 7) ? 32'h1 : 32'h0);
            chk("iow_ack", 32'(bus0.acknowledge),     (c == 7) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 7) chk("iow_dout", 32'(bus0.data_out), 32'h3C);
            if (c == 1) chk("iow_addr", 32'(bus0.address), 32'h00061);
            if (c == 6) bus0.ready = 1'b1;
        end

        // Forced waits on the WAIT_STATES=2 instance
        bus2.ready = 1'b1;
        bus2.request = 1'b1; bus2.request_type = 3'b110;
        bus2.request_address = 20'hABCDE; bus2.request_write_data = 8'h99;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus2.request = 1'b0;
            chk("ws2_status", 32'(bus2.processor_status), (c <= 5) ? 32'h6 : 32'h7);
            chk("ws2_ack", 32'(bus2.acknowledge),     (c == 6) ? 32'h1 : 32'h0);
            chk("ws2_oe",  32'(bus2.data_out_enable), (c >= 2 && c <= 6) ? 32'h1 : 32'h0);
        end

        // Halt ignores ready
        bus0.ready = 1'b0;
        start0(3'b011, 20'h00000, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus0.request = 1'b0;
            chk("hlt_status", 32'(bus0.processor_status), (c <= 3) ? 32'h3 : 32'h7);
            chk("hlt_ack",    32'(bus0.acknowledge),      (c == 4) ? 32'h1 : 32'h0);
        end
        bus0.ready = 1'b1;

        // Back-to-back code fetches with request held
        bus0.data_in = 8'hA5;
        start0(3'b100, 20'h00100, 8'h00);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock); cyc_no = c;
            chk("b2b_status", 32'(bus0.processor_status),
                (c == 4 || c >= 8) ? 32'h7 : 32'h4);
            chk("b2b_ack", 32'(bus0.acknowledge),   (c == 4 || c == 8) ? 32'h1 : 32'h0);
            chk("b2b_rdy", 32'(bus0.request_ready), (c == 4 || c >= 8) ? 32'h1 : 32'h0);
            if (c == 4) chk("b2b_rdata1", 32'(bus0.read_data), 32'hA5);
            if (c == 5) bus0.data_in = 8'h3E;
            if (c == 8) begin
                chk("b2b_rdata2", 32'(bus0.read_data), 32'h3E);
                bus0.request = 1'b0;
            end
        end

        // Reset during TW of an IO read
        bus0.ready = 1'b0;
        start0(3'b001, 20'h003F8, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus0.request = 1'b0;
        end
        chk("abt_tw_status", 32'(bus0.processor_status), 32'h1);
        reset = 1'b1;
        #1;
        chk("abt_status", 32'(bus0.processor_status), 32'h7);
        chk("abt_ack",    32'(bus0.acknowledge),      32'h0);
        chk("abt_rdy",    32'(bus0.request_ready),    32'h1);
        chk("abt_addr",   32'(bus0.address),          32'h0);
        @(negedge clock);
        reset = 1'b0; bus0.ready = 1'b1; bus0.data_in = 8'hC3;
        start0(3'b000, 20'h00000, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock); cyc_no = c;
            if (c == 1) bus0.request = 1'b0;
            chk("inta_status", 32'(bus0.processor_status), (c <= 3) ? 32'h0 : 32'h7);
            chk("inta_ack",    32'(bus0.acknowledge),      (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) chk("inta_rdata", 32'(bus0.read_data), 32'hC3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kf8088_bus_cycle_gen.md
# kf8088_bus_cycle_gen

Bus-cycle initiator for the KFPC-XT: turns a simple request/acknowledge transaction from internal logic into 8088-style bus cycles, driving the active-low processor status lines `processor_status[2:0]` that the 8288 bus controller decodes into commands. It sequences T1–T4 plus wait states and honours the `ready` input. It supplies the address and write data and captures read data. It is the initiating end of the status interface that the 8288 terminates.

## Interface
Parameters:
- `WAIT_STATES`, default 0: forced TW cycles inserted in every non-halt cycle, in addition to any requested by `ready`.

Ports:
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `request` in 1: transaction valid.
- `request_ready` out 1: block can accept; high in IDLE and T4.
- `request_type` in 3: status code to issue (000 INTA, 001 IO read, 010 IO write, 011 halt, 100 code fetch, 101 mem read, 110 mem write; 111 illegal, request ignored).
- `request_address` in 20: cycle address.
- `request_write_data` in 8: write data.
- `processor_status` out 3: S_n[2:0] to the 8288; 111 = passive.
- `address` out 20: registered cycle address.
- `data_out` out 8: registered write data.
- `data_out_enable` out 1: write data drive enable.
- `data_in` in 8: bus read data.
- `ready` in 1: synchronised READY; low requests wait states.
- `acknowledge` out 1: one-cycle completion pulse.
- `read_data` out 8: data captured for the completed cycle; holds until the next capture.

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- Acceptance: `request && request_ready && request_type != 111` at a rising edge. That edge registers type, address and write data, loads the wait counter with `WAIT_STATES`, and enters T1.
- IDLE → T1 on acceptance; otherwise stay in IDLE.
- T1 → T2 → T3 unconditionally.
- T3 or TW → T4 when the wait counter is 0 and `ready` is 1. Otherwise → TW, and the counter decrements if nonzero.
- Halt cycles (011) ignore `ready` and the counter: T3 → T4 always.
- T4 → T1 on a new acceptance, else → IDLE.
- `processor_status` carries the registered type in T1, T2, T3 and TW. It is 111 in IDLE and T4.
- `address` is valid T1–T4.
- `data_out_enable` is high T2–T4 for type 010 or 110, else low.
- Read capture: on the edge leaving T3/TW into T4, `read_data` takes `data_in` for types 000, 001, 100 and 101.
- `acknowledge` is high exactly during T4.
- `request_ready` is combinational from state only, with no dependency on `request`.

## Timing
- Reset values: state IDLE, `processor_status` 111, `address` 0, `data_out` 0, `data_out_enable` 0, `acknowledge` 0, `read_data` 0, wait counter 0. `request_ready` is therefore 1.
- Latency: with acceptance at edge 0, T1 is cycle 1 and `acknowledge` is cycle 4 + W. W is the number of TW cycles, at least `WAIT_STATES` for non-halt cycles.
- `ready` is sampled only at the end of T3/TW, once the counter is 0. Its value in other states is ignored.
- Back-to-back: a request held through T4 is accepted at the end of T4. Status then goes 111 for exactly one cycle (T4) between cycles, which gives the 8288 its passive edge.
- Reset mid-cycle, in any state: outputs return to reset values immediately, without waiting for a clock edge. No `acknowledge` is issued for the aborted cycle.
- Illegal type 111 is never accepted; `request_ready` stays high.
- Counter width is ceil(log2(`WAIT_STATES`+1)), minimum 1.

## Structure
- Shared package `kf8088_pkg`:
  - status code constants (STATUS_INTA … STATUS_PASSIVE);
  - bus-state enum;
  - helper functions `is_write(type)` and `is_read(type)`.
- Single module; no sub-module needed. The wait counter stays inline.

## Test plan
- Mem read, `ready`=1, `WAIT_STATES`=0, address 0xF_FFF0, `data_in`=0x5A:
  - `processor_status`=101 in cycles 1–3 and 111 in cycle 4;
  - `acknowledge` in cycle 4;
  - `read_data`=0x5A.
- IO write 0x3C to 0x0061, `ready` low for the first 3 samples:
  - 3 TW cycles with status 010 held;
  - `data_out_enable` high cycles 2–7 with `data_out`=0x3C;
  - `acknowledge` in cycle 7.
- `WAIT_STATES`=2, mem write, `ready`=1: 2 TW cycles, `acknowledge` in cycle 6.
- Halt with `ready`=0: status 011 in cycles 1–3, `acknowledge` in cycle 4, no TW.
- Back-to-back code fetches with `request` held high: status is 100,100,100,111,100… with exactly one passive cycle between fetches; two `acknowledge` pulses 4 cycles apart.
- Reset asserted during TW of an IO read:
  - `processor_status`=111 and `acknowledge`=0 immediately;
  - after release, a new INTA completes with `acknowledge` in cycle 4 and `read_data`=`data_in`.
